// File: rtl/spi_slave_driver_pkg.sv
// Shared SPI definitions: FSM state encoding and slave-select level helper,
// common to the master and slave drivers.
package spi_slave_driver_pkg;

   typedef enum logic [1:0] {
      STATE_IDLE  = 2'd0,
      STATE_LOAD  = 2'd1,
      STATE_SHIFT = 2'd2,
      STATE_RESET = 2'd3
   } spi_state_e;

   // Pin level of SS for a given logical assertion.
   function automatic logic ss_level(input logic asserted, input logic active_low);
      return asserted ^ active_low;
   endfunction

endpackage

// File: rtl/spi_slave_driver_input_synchronizer.sv
// Multi-stage synchronizer for an asynchronous pin, with optional registered
// rise/fall strobes taken against one further registered copy.
module spi_slave_driver_input_synchronizer #(
   parameter int unsigned STAGES      = 2,
   parameter logic        RESET_VAL   = 1'b0,
   parameter bit          EDGE_DETECT = 1'b1
) (
   input  logic sys_clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              level;

   always_comb begin
      sync_d = STAGES'({sync_q, din});
   end

   always_ff @(posedge sys_clk) begin
      if (rst) sync_q <= {STAGES{RESET_VAL}};
      else     sync_q <= sync_d;
   end

   assign level = sync_q[STAGES-1];
   assign dout  = level;

   generate
      if (EDGE_DETECT) begin : g_edge
         logic last_q, last_d, rise_q, rise_d, fall_q, fall_d;

         always_comb begin
            last_d = level;
            rise_d = level & ~last_q;
            fall_d = ~level & last_q;
         end

         always_ff @(posedge sys_clk) begin
            if (rst) begin
               last_q <= RESET_VAL;
               rise_q <= 1'b0;
               fall_q <= 1'b0;
            end else begin
               last_q <= last_d;
               rise_q <= rise_d;
               fall_q <= fall_d;
            end
         end

         assign rise = rise_q;
         assign fall = fall_q;
      end else begin : g_no_edge
         assign rise = 1'b0;
         assign fall = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/spi_slave_driver.sv
// SPI mode-0 slave PHY: oversamples SS/SCLK/MOSI on sys_clk, deserialises MOSI
// words and serialises MISO words, with back-to-back words under one SS.
module spi_slave_driver
   import spi_slave_driver_pkg::*;
#(
   parameter bit          SS_ACTIVE_LOW = 1'b1,
   parameter bit          LSB_FIRST     = 1'b0,
   parameter int unsigned NUM_DATA_BITS = 8
) (
   input  logic                     sys_clk,
   input  logic                     rst,
   output logic                     bus_active,
   output logic                     mosi_new_data,
   output logic [NUM_DATA_BITS-1:0] mosi_data,
   input  logic [NUM_DATA_BITS-1:0] miso_data,
   output logic                     miso_load,
   input  logic                     ss_in,
   input  logic                     sclk_in,
   input  logic                     mosi_in,
   output logic                     miso_out
);

   localparam int unsigned CNT_W       = $clog2(NUM_DATA_BITS + 1);
   localparam logic        SS_IDLE_LVL = ss_level(1'b0, SS_ACTIVE_LOW);

   logic ss_sync, ss_rise, ss_fall;
   logic sclk_level_unused, sclk_rise, sclk_fall;
   logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

   spi_slave_driver_input_synchronizer #(.STAGES(2), .RESET_VAL(SS_IDLE_LVL), .EDGE_DETECT(1'b1)) u_ss_sync (
      .sys_clk(sys_clk), .rst(rst), .din(ss_in), .dout(ss_sync), .rise(ss_rise), .fall(ss_fall)
   );

   spi_slave_driver_input_synchronizer #(.STAGES(2), .RESET_VAL(1'b0), .EDGE_DETECT(1'b1)) u_sclk_sync (
      .sys_clk(sys_clk), .rst(rst), .din(sclk_in), .dout(sclk_level_unused), .rise(sclk_rise),
      .fall(sclk_fall)
   );

   spi_slave_driver_input_synchronizer #(.STAGES(2), .RESET_VAL(1'b0), .EDGE_DETECT(1'b0)) u_mosi_sync (
      .sys_clk(sys_clk), .rst(rst), .din(mosi_in), .dout(mosi_sync), .rise(mosi_rise_unused),
      .fall(mosi_fall_unused)
   );

   logic ss_active, ss_assert, ss_deassert;
   assign ss_active   = (ss_sync != SS_IDLE_LVL);
   assign ss_assert   = SS_ACTIVE_LOW ? ss_fall : ss_rise;
   assign ss_deassert = SS_ACTIVE_LOW ? ss_rise : ss_fall;

   function automatic logic first_bit(input logic [NUM_DATA_BITS-1:0] w);
      return LSB_FIRST ? w[0] : w[NUM_DATA_BITS-1];
   endfunction

   spi_state_e               state_q, state_d;
   logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d, cnt_inc;
   logic [NUM_DATA_BITS-1:0] rx_q, rx_d, rx_shift;
   logic [NUM_DATA_BITS-1:0] tx_q, tx_d, tx_shift;
   logic                     word_done_q, word_done_d;
   logic                     bus_active_q, bus_active_d;
   logic                     mosi_new_data_q, mosi_new_data_d;
   logic [NUM_DATA_BITS-1:0] mosi_data_q, mosi_data_d;
   logic                     miso_load_q, miso_load_d;
   logic                     miso_out_q, miso_out_d;

   always_comb begin
      state_d         = state_q;
      bit_cnt_d       = bit_cnt_q;
      rx_d            = rx_q;
      tx_d            = tx_q;
      word_done_d     = word_done_q;
      bus_active_d    = ss_active;
      mosi_new_data_d = 1'b0;
      mosi_data_d     = mosi_data_q;
      miso_load_d     = 1'b0;
      miso_out_d      = miso_out_q;

      rx_shift = LSB_FIRST ? NUM_DATA_BITS'({mosi_sync, rx_q} >> 1) : NUM_DATA_BITS'({rx_q, mosi_sync});
      tx_shift = LSB_FIRST ? (tx_q >> 1) : (tx_q << 1);
      cnt_inc  = bit_cnt_q + CNT_W'(1);

      // SS release outranks any coincident SCLK edge and drops a partial word.
      if (ss_deassert) begin
         state_d     = STATE_IDLE;
         miso_out_d  = 1'b0;
         bit_cnt_d   = '0;
         word_done_d = 1'b0;
      end else begin
         case (state_q)
            STATE_IDLE: begin
               miso_out_d  = 1'b0;
               bit_cnt_d   = '0;
               word_done_d = 1'b0;
               // First bit goes out with the load so MISO lands 4 cycles after SS assert.
               if (ss_assert) begin
                  tx_d        = miso_data;
                  miso_load_d = 1'b1;
                  miso_out_d  = first_bit(miso_data);
                  state_d     = STATE_LOAD;
               end
            end
            STATE_LOAD: begin
               miso_out_d = first_bit(tx_q);
               state_d    = STATE_SHIFT;
            end
            STATE_SHIFT: begin
               if (sclk_rise) begin
                  rx_d = rx_shift;
                  if (cnt_inc == CNT_W'(NUM_DATA_BITS)) begin
                     mosi_data_d     = rx_shift;
                     mosi_new_data_d = 1'b1;
                     bit_cnt_d       = '0;
                     word_done_d     = 1'b1;
                  end else begin
                     bit_cnt_d = cnt_inc;
                  end
               end else if (sclk_fall) begin
                  if (word_done_q) begin
                     tx_d        = miso_data;
                     miso_load_d = 1'b1;
                     miso_out_d  = first_bit(miso_data);
                     word_done_d = 1'b0;
                  end else begin
                     tx_d       = tx_shift;
                     miso_out_d = first_bit(tx_shift);
                  end
               end
            end
            default: state_d = STATE_IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q         <= STATE_IDLE;
         bit_cnt_q       <= '0;
         rx_q            <= '0;
         tx_q            <= '0;
         word_done_q     <= 1'b0;
         bus_active_q    <= 1'b0;
         mosi_new_data_q <= 1'b0;
         mosi_data_q     <= '0;
         miso_load_q     <= 1'b0;
         miso_out_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         bit_cnt_q       <= bit_cnt_d;
         rx_q            <= rx_d;
         tx_q            <= tx_d;
         word_done_q     <= word_done_d;
         bus_active_q    <= bus_active_d;
         mosi_new_data_q <= mosi_new_data_d;
         mosi_data_q     <= mosi_data_d;
         miso_load_q     <= miso_load_d;
         miso_out_q      <= miso_out_d;
      end
   end

   assign bus_active    = bus_active_q;
   assign mosi_new_data = mosi_new_data_q;
   assign mosi_data     = mosi_data_q;
   assign miso_load     = miso_load_q;
   assign miso_out      = miso_out_q;

endmodule

// File: tb/tb_spi_slave_driver.sv
// Directed bench for spi_slave_driver acting as the SPI master: 8-bit MSB-first,
// 8-bit LSB-first and 16-bit instances share SCLK/MOSI with separate SS lines.
module tb_spi_slave_driver;

   logic sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   logic rst, sclk, mosi, ss0, ss1, ss2;
   logic [7:0]  miso_data0, miso_data1, mosi_data0, mosi_data1;
   logic [15:0] miso_data2, mosi_data2;
   logic bus_active0, bus_active1, bus_active2;
   logic mnd0, mnd1, mnd2, mld0, mld1, mld2, miso0, miso1, miso2;
   int   sel;
   logic miso_sel;

   spi_slave_driver u0 (
      .sys_clk(sys_clk), .rst(rst), .bus_active(bus_active0), .mosi_new_data(mnd0),
      .mosi_data(mosi_data0), .miso_data(miso_data0), .miso_load(mld0), .ss_in(ss0),
      .sclk_in(sclk), .mosi_in(mosi), .miso_out(miso0)
   );

   spi_slave_driver #(.LSB_FIRST(1)) u1 (
      .sys_clk(sys_clk), .rst(rst), .bus_active(bus_active1), .mosi_new_data(mnd1),
      .mosi_data(mosi_data1), .miso_data(miso_data1), .miso_load(mld1), .ss_in(ss1),
      .sclk_in(sclk), .mosi_in(mosi), .miso_out(miso1)
   );

   spi_slave_driver #(.NUM_DATA_BITS(16)) u2 (
      .sys_clk(sys_clk), .rst(rst), .bus_active(bus_active2), .mosi_new_data(mnd2),
      .mosi_data(mosi_data2), .miso_data(miso_data2), .miso_load(mld2), .ss_in(ss2),
      .sclk_in(sclk), .mosi_in(mosi), .miso_out(miso2)
   );

   assign miso_sel = (sel == 0) ? miso0 : (sel == 1) ? miso1 : miso2;

   int nd_cnt[3];
   int ld_cnt[3];
   logic [7:0] word_q0[$];

   initial begin
      for (int i = 0; i < 3; i++) begin
         nd_cnt[i] = 0;
         ld_cnt[i] = 0;
      end
   end

   always @(posedge sys_clk) begin
      if (mnd0) begin
         nd_cnt[0] <= nd_cnt[0] + 1;
         word_q0.push_back(mosi_data0);
      end
      if (mnd1) nd_cnt[1] <= nd_cnt[1] + 1;
      if (mnd2) nd_cnt[2] <= nd_cnt[2] + 1;
      if (mld0) ld_cnt[0] <= ld_cnt[0] + 1;
      if (mld1) ld_cnt[1] <= ld_cnt[1] + 1;
      if (mld2) ld_cnt[2] <= ld_cnt[2] + 1;
   end

   int checks = 0;
   int passed = 0;

   task automatic cyc(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   // Master side: MOSI changes with SCLK low, MISO sampled at the end of SCLK high.
   task automatic xfer(input int sel_i, input logic [31:0] tx, input int nbits, input bit lsb,
                       output logic [31:0] rx);
      rx  = '0;
      sel = sel_i;
      for (int i = 0; i < nbits; i++) begin
         int idx;
         idx  = lsb ? i : nbits - 1 - i;
         sclk = 1'b0;
         mosi = tx[idx];
         cyc(3);
         sclk = 1'b1;
         cyc(3);
         rx[idx] = miso_sel;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; sclk = 1'b0; mosi = 1'b0; ss0 = 1'b1; ss1 = 1'b1; ss2 = 1'b1;
      miso_data0 = 8'h00; miso_data1 = 8'h00; miso_data2 = 16'h0000; sel = 0;
      cyc(3);
      rst = 1'b0;
      cyc(2);
      checks++; if (bus_active0 !== 1'b0) $display("FAIL reset_bus_active: got %b expected 0", bus_active0); else passed++;
      checks++; if (mnd0 !== 1'b0) $display("FAIL reset_mosi_new_data: got %b expected 0", mnd0); else passed++;
      checks++; if (mosi_data0 !== 8'h00) $display("FAIL reset_mosi_data: got %h expected 00", mosi_data0); else passed++;
      checks++; if (mld0 !== 1'b0) $display("FAIL reset_miso_load: got %b expected 0", mld0); else passed++;
      checks++; if (miso0 !== 1'b0) $display("FAIL reset_miso_out: got %b expected 0", miso0); else passed++;
      checks++; if (mosi_data2 !== 16'h0000) $display("FAIL reset_mosi_data16: got %h expected 0000", mosi_data2); else passed++;
   endtask

   task automatic test_single_word();
      logic [31:0] rx;
      int nb, lb;
      nb = nd_cnt[0]; lb = ld_cnt[0];
      miso_data0 = 8'h3C;
      ss0 = 1'b0;
      cyc(4);
      checks++; if (bus_active0 !== 1'b1) $display("FAIL single_bus_active: got %b expected 1", bus_active0); else passed++;
      xfer(0, 32'hA5, 8, 1'b0, rx);
      checks++; if (ld_cnt[0] - lb !== 1) $display("FAIL single_miso_load_count: got %0d expected 1", ld_cnt[0] - lb); else passed++;
      checks++; if (rx[7:0] !== 8'h3C) $display("FAIL single_miso_stream: got %h expected 3c", rx[7:0]); else passed++;
      checks++; if (mnd0 !== 1'b0) $display("FAIL single_strobe_early: got %b expected 0", mnd0); else passed++;
      cyc(1);
      checks++; if (mnd0 !== 1'b1) $display("FAIL single_strobe_latency: got %b expected 1", mnd0); else passed++;
      checks++; if (mosi_data0 !== 8'hA5) $display("FAIL single_mosi_data: got %h expected a5", mosi_data0); else passed++;
      cyc(1);
      checks++; if (mnd0 !== 1'b0) $display("FAIL single_strobe_width: got %b expected 0", mnd0); else passed++;
      checks++; if (nd_cnt[0] - nb !== 1) $display("FAIL single_strobe_count: got %0d expected 1", nd_cnt[0] - nb); else passed++;
      sclk = 1'b0;
      cyc(3);
      ss0 = 1'b1;
      cyc(4);
      checks++; if (miso0 !== 1'b0) $display("FAIL single_miso_idle: got %b expected 0", miso0); else passed++;
      checks++; if (bus_active0 !== 1'b0) $display("FAIL single_bus_idle: got %b expected 0", bus_active0); else passed++;
      cyc(2);
   endtask

   task automatic test_back_to_back();
      logic [31:0] rxa, rxb;
      int nb, lb, qb;
      nb = nd_cnt[0]; lb = ld_cnt[0]; qb = word_q0.size();
      miso_data0 = 8'h55;
      ss0 = 1'b0;
      cyc(4);
      xfer(0, 32'h12, 8, 1'b0, rxa);
      miso_data0 = 8'hAA;
      xfer(0, 32'h34, 8, 1'b0, rxb);
      checks++; if (ld_cnt[0] - lb !== 2) $display("FAIL b2b_miso_load_count: got %0d expected 2", ld_cnt[0] - lb); else passed++;
      cyc(2);
      checks++; if (rxa[7:0] !== 8'h55) $display("FAIL b2b_miso_word0: got %h expected 55", rxa[7:0]); else passed++;
      checks++; if (rxb[7:0] !== 8'hAA) $display("FAIL b2b_miso_word1: got %h expected aa", rxb[7:0]); else passed++;
      checks++; if (nd_cnt[0] - nb !== 2) $display("FAIL b2b_strobe_count: got %0d expected 2", nd_cnt[0] - nb); else passed++;
      if (word_q0.size() >= qb + 2) begin
         checks++; if (word_q0[qb] !== 8'h12) $display("FAIL b2b_mosi_word0: got %h expected 12", word_q0[qb]); else passed++;
         checks++; if (word_q0[qb+1] !== 8'h34) $display("FAIL b2b_mosi_word1: got %h expected 34", word_q0[qb+1]); else passed++;
      end else begin
         checks++; $display("FAIL b2b_words_logged: got %0d expected 2", word_q0.size() - qb);
      end
      sclk = 1'b0;
      cyc(3);
      ss0 = 1'b1;
      cyc(6);
   endtask

   task automatic test_ss_abort();
      logic [31:0] rx;
      int nb;
      nb = nd_cnt[0];
      miso_data0 = 8'hF0;
      ss0 = 1'b0;
      cyc(4);
      xfer(0, 32'h1F, 5, 1'b0, rx);
      checks++; if (rx[4:0] !== 5'h1E) $display("FAIL abort_partial_miso: got %h expected 1e", rx[4:0]); else passed++;
      sclk = 1'b0;
      cyc(3);
      ss0 = 1'b1;
      cyc(4);
      checks++; if (miso0 !== 1'b0) $display("FAIL abort_miso_idle: got %b expected 0", miso0); else passed++;
      checks++; if (bus_active0 !== 1'b0) $display("FAIL abort_bus_idle: got %b expected 0", bus_active0); else passed++;
      cyc(4);
      checks++; if (nd_cnt[0] - nb !== 0) $display("FAIL abort_no_strobe: got %0d expected 0", nd_cnt[0] - nb); else passed++;
      checks++; if (mosi_data0 !== 8'h34) $display("FAIL abort_mosi_held: got %h expected 34", mosi_data0); else passed++;
      miso_data0 = 8'h0F;
      ss0 = 1'b0;
      cyc(4);
      xfer(0, 32'h5A, 8, 1'b0, rx);
      cyc(2);
      checks++; if (mosi_data0 !== 8'h5A) $display("FAIL abort_next_mosi: got %h expected 5a", mosi_data0); else passed++;
      checks++; if (rx[7:0] !== 8'h0F) $display("FAIL abort_next_miso: got %h expected 0f", rx[7:0]); else passed++;
      sclk = 1'b0;
      cyc(3);
      ss0 = 1'b1;
      cyc(6);
   endtask

   task automatic test_reset_mid_word();
      logic [31:0] rx;
      int nb;
      nb = nd_cnt[0];
      miso_data0 = 8'hFF;
      ss0 = 1'b0;
      cyc(4);
      xfer(0, 32'h7, 3, 1'b0, rx);
      rst = 1'b1; sclk = 1'b0; ss0 = 1'b1;
      cyc(1);
      checks++; if (bus_active0 !== 1'b0) $display("FAIL midrst_bus_active: got %b expected 0", bus_active0); else passed++;
      checks++; if (mosi_data0 !== 8'h00) $display("FAIL midrst_mosi_data: got %h expected 00", mosi_data0); else passed++;
      checks++; if (mnd0 !== 1'b0) $display("FAIL midrst_mosi_new_data: got %b expected 0", mnd0); else passed++;
      checks++; if (miso0 !== 1'b0) $display("FAIL midrst_miso_out: got %b expected 0", miso0); else passed++;
      checks++; if (mld0 !== 1'b0) $display("FAIL midrst_miso_load: got %b expected 0", mld0); else passed++;
      rst = 1'b0;
      cyc(4);
      miso_data0 = 8'h96;
      ss0 = 1'b0;
      cyc(4);
      xfer(0, 32'hC3, 8, 1'b0, rx);
      cyc(2);
      checks++; if (mosi_data0 !== 8'hC3) $display("FAIL midrst_next_mosi: got %h expected c3", mosi_data0); else passed++;
      checks++; if (rx[7:0] !== 8'h96) $display("FAIL midrst_next_miso: got %h expected 96", rx[7:0]); else passed++;
      checks++; if (nd_cnt[0] - nb !== 1) $display("FAIL midrst_strobe_count: got %0d expected 1", nd_cnt[0] - nb); else passed++;
      sclk = 1'b0;
      cyc(3);
      ss0 = 1'b1;
      cyc(6);
   endtask

   task automatic test_lsb_first();
      logic [31:0] rx;
      int nb, lb;
      nb = nd_cnt[1]; lb = ld_cnt[1];
      miso_data1 = 8'h81;
      ss1 = 1'b0;
      cyc(4);
      xfer(1, 32'hA5, 8, 1'b1, rx);
      checks++; if (ld_cnt[1] - lb !== 1) $display("FAIL lsb_miso_load_count: got %0d expected 1", ld_cnt[1] - lb); else passed++;
      cyc(2);
      checks++; if (mosi_data1 !== 8'hA5) $display("FAIL lsb_mosi_data: got %h expected a5", mosi_data1); else passed++;
      checks++; if (rx[7:0] !== 8'h81) $display("FAIL lsb_miso_stream: got %h expected 81", rx[7:0]); else passed++;
      checks++; if (nd_cnt[1] - nb !== 1) $display("FAIL lsb_strobe_count: got %0d expected 1", nd_cnt[1] - nb); else passed++;
      sclk = 1'b0;
      cyc(3);
      ss1 = 1'b1;
      cyc(6);
   endtask

   task automatic test_loopback16();
      logic [31:0] rx;
      int nb, lb;
      nb = nd_cnt[2]; lb = ld_cnt[2];
      miso_data2 = 16'h1234;
      ss2 = 1'b0;
      cyc(4);
      xfer(2, 32'hBEEF, 16, 1'b0, rx);
      checks++; if (ld_cnt[2] - lb !== 1) $display("FAIL loop16_miso_load_count: got %0d expected 1", ld_cnt[2] - lb); else passed++;
      cyc(2);
      checks++; if (mosi_data2 !== 16'hBEEF) $display("FAIL loop16_mosi_data: got %h expected beef", mosi_data2); else passed++;
      checks++; if (rx[15:0] !== 16'h1234) $display("FAIL loop16_miso_data: got %h expected 1234", rx[15:0]); else passed++;
      checks++; if (nd_cnt[2] - nb !== 1) $display("FAIL loop16_strobe_count: got %0d expected 1", nd_cnt[2] - nb); else passed++;
      sclk = 1'b0;
      cyc(3);
      ss2 = 1'b1;
      cyc(6);
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_ss_abort();
      test_reset_mid_word();
      test_lsb_first();
      test_loopback16();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/spi_slave_driver.md
Name: spi_slave_driver

Overview:
SPI slave physical-layer driver, mode 0 (CPOL=0, CPHA=0) only. It is the bus-side counterpart of the SPI master driver. It oversamples SS, SCLK and MOSI on sys_clk, shifts in MOSI words and shifts out MISO words. Each received word is presented to the upstream logic with a one-cycle strobe, and the next MISO word is taken from the upstream logic. It sits between the target-facing SPI pins and the MITM data path.

Parameters:
- SS_ACTIVE_LOW, 1, SS asserted level is 0 when 1, 1 when 0.
- LSB_FIRST, 0, bit order for both MOSI and MISO; 0 = MSB first.
- NUM_DATA_BITS, 8, bits per word in both directions; range 1..32.

Ports:
- sys_clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- bus_active  out  1  high while synchronized SS is asserted.
- mosi_new_data  out  1  one-cycle strobe: a complete word is valid on mosi_data.
- mosi_data  out  NUM_DATA_BITS  last completed MOSI word; held until the next completed word.
- miso_data  in  NUM_DATA_BITS  word to transmit; sampled at the load points defined below.
- miso_load  out  1  one-cycle strobe in the cycle miso_data is sampled.
- ss_in  in  1  SS line (asynchronous).
- sclk_in  in  1  SCLK line (asynchronous).
- mosi_in  in  1  MOSI line (asynchronous).
- miso_out  out  1  MISO line; 0 when not active (tri-state handled at top level).

Behaviour:
- Synchronization: ss_in, sclk_in and mosi_in each pass through a 2-FF synchronizer. SS/SCLK edges are detected against a third registered copy.
  - SS synchronizer FFs reset to the inactive level; SCLK and MOSI FFs reset to 0.
- Timing constraints on the bus:
  - SCLK high and low phases each ≥3 sys_clk periods.
  - SS setup to the first SCLK rise ≥3 sys_clk.
  - SCLK last fall to SS deassert ≥3 sys_clk.
  - These match the master driver with CLOCK_DIV ≥ 6.
- Reset values: bus_active=0, mosi_new_data=0, mosi_data=0, miso_load=0, miso_out=0, bit counter=0, state=IDLE.
- rst has priority over every event. A mid-word reset discards the partial word and raises no strobe.
- FSM states:
  - IDLE: miso_out=0, bit counter=0. On the SS-assert edge: sample miso_data, pulse miso_load, go to LOAD.
  - LOAD: one cycle. Drive the first MISO bit (LSB or MSB per LSB_FIRST) onto miso_out, then go to SHIFT.
  - SHIFT, on synchronized SCLK rise:
    - Shift the synchronized MOSI bit into the receive register and increment the bit counter.
    - When the counter reaches NUM_DATA_BITS: copy the register to mosi_data, pulse mosi_new_data in the next cycle, clear the counter, set the word_done flag.
  - SHIFT, on synchronized SCLK fall:
    - word_done=0: present the next MISO bit.
    - word_done=1: sample miso_data, pulse miso_load, present the new word's first bit, clear word_done. This supports back-to-back words under one SS.
  - Any state, SS-deassert edge: go to IDLE, drive miso_out=0, clear the counter and word_done. A partial word is discarded, with no mosi_new_data strobe and mosi_data unchanged.
- Latency:
  - mosi_new_data rises 4 sys_clk after the sclk_in pin rise of the last bit: 2 sync + 1 edge + 1 output register.
  - miso_out changes 4 sys_clk after an sclk_in fall or SS assert.
- Simultaneous events:
  - An SS deassert edge coincident with an SCLK edge: SS wins, and the SCLK edge is ignored.
  - An SCLK edge while in LOAD cannot occur under the timing constraints. If one does, it is ignored.
- Counter width is clog2(NUM_DATA_BITS+1). The counter wraps to 0 only on word completion.
- NUM_DATA_BITS=1: every rise completes a word, and every fall reloads.

Decomposition:
- Shared SPI package: mode/state constants (STATE_IDLE, STATE_LOAD, STATE_SHIFT, STATE_RESET) and the SS level helper, shared with the master driver.
- One sub-module: input_synchronizer (parameterized stage count, registered rise/fall outputs), instantiated for SS and SCLK; MOSI uses a data-only instance.
- The MISO shift path reuses the codebase's serial write buffer behaviour inline; no extra module.

Test Plan:
- Single word, SS low, 8 SCLKs at 6 sys_clk per bit, MOSI=0xA5, miso_data=0x3C -> mosi_data=0xA5 with one mosi_new_data pulse; MISO bit stream 0,0,1,1,1,1,0,0; one miso_load pulse at SS assert.
- LSB_FIRST=1, MOSI 0xA5 sent LSB first, miso_data=0x81 -> mosi_data=0xA5; MISO stream 1,0,0,0,0,0,0,1.
- Two back-to-back words under one SS: MOSI 0x12, 0x34; miso_data changes 0x55 to 0xAA after the first miso_load -> two strobes with 0x12 then 0x34; MISO carries 0x55 then 0xAA; exactly two miso_load pulses.
- SS deasserted after 5 SCLKs -> no mosi_new_data; mosi_data keeps its previous value; miso_out=0 within 4 cycles; the next full word is received correctly.
- rst asserted mid-word at bit 3 -> all outputs take reset values on the next cycle; a subsequent full transfer with 0xC3 is received correctly.
- Loopback with the SPI master driver (CLOCK_DIV=6, NUM_DATA_BITS=16): master sends 0xBEEF, slave returns 0x1234 -> slave mosi_data=0xBEEF, master miso_data=0x1234.
